seven_seg_scan: RTL

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_pkg.sv | 26 ++
 rtl/hex_to_inverse_seven_seg.sv | 32 +++
 rtl/seven_seg_scan.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
package seven_seg_pkg;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } scan_state_e;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // Digit idx is a leading zero when it and every more-significant nibble are zero.
  function automatic logic lz_dark(input logic [15:0] disp, input logic [1:0] idx);
    logic dark;
    case (idx)
      2'd0:    dark = 1'b0;
      2'd1:    dark = (disp[15:4] == 12'h000);
      2'd2:    dark = (disp[15:8] == 8'h00);
      2'd3:    dark = (disp[15:12] == 4'h0);
      default: dark = 1'b0;
    endcase
    return dark;
  endfunction

endpackage

// File: rtl/hex_to_inverse_seven_seg.sv
// Hex nibble to active-low segment pattern, segment a in bit 6 through g in bit 0.
module hex_to_inverse_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  // Pure lookup; no state.
  always_comb begin
    case (nibble_i)
      4'h0:    seg_n_o = 7'b0000001;
      4'h1:    seg_n_o = 7'b1001111;
      4'h2:    seg_n_o = 7'b0010010;
      4'h3:    seg_n_o = 7'b0000110;
      4'h4:    seg_n_o = 7'b1001100;
      4'h5:    seg_n_o = 7'b0100100;
      4'h6:    seg_n_o = 7'b0100000;
      4'h7:    seg_n_o = 7'b0001111;
      4'h8:    seg_n_o = 7'b0000000;
      4'h9:    seg_n_o = 7'b0000100;
      4'hA:    seg_n_o = 7'b0001000;
      4'hB:    seg_n_o = 7'b1100000;
      4'hC:    seg_n_o = 7'b0110001;
      4'hD:    seg_n_o = 7'b1000010;
      4'hE:    seg_n_o = 7'b0110000;
      4'hF:    seg_n_o = 7'b0111000;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for four common-anode digits with blanking guard,
// frame-synchronous value update, per-digit enable and leading-zero suppression.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_start
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_s;
  logic [15:0]      shadow_q, shadow_d, disp_q, disp_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d, seg_s;
  logic             dp_q, dp_d, fs_q, fs_d;
  logic [3:0]       nibble_s;
  logic             dark_s, en_s;

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // idx advances when leaving ACTIVE so the post-reset guard leads straight into digit 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    wrap_s  = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (cnt_q == ACT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          wrap_s  = (idx_q == 2'd3);
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLK_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          state_d = ST_BLANK;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  assign nibble_s = disp_q[{idx_q, 2'b00} +: 4];

  hex_to_inverse_seven_seg u_hex (
    .nibble_i (nibble_s),
    .seg_n_o  (seg_s)
  );

  // Output decode; the registered copy lags the state by one cycle.
  always_comb begin
    dark_s      = lz_en & lz_dark(disp_q, idx_q);
    en_s        = digit_en[idx_q];
    shadow_d    = load ? value : shadow_q;
    shadow_dp_d = load ? dp_in : shadow_dp_q;
    disp_d      = wrap_s ? shadow_q : disp_q;
    disp_dp_d   = wrap_s ? shadow_dp_q : disp_dp_q;
    fs_d        = (state_q == ST_BLANK) && (cnt_q == BLK_LAST) && (idx_q == 2'd0);
    an_d        = AN_OFF;
    seg_d       = SEG_OFF;
    dp_d        = 1'b1;
    if (state_q == ST_ACTIVE) begin
      an_d = en_s ? ~(4'b0001 << idx_q) : AN_OFF;
      if (en_s && !dark_s) begin
        seg_d = seg_s;
        dp_d  = ~disp_dp_q[idx_q];
      end else begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
      end
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  // Shadow/display data and registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= 16'h0000;
      shadow_dp_q <= 4'h0;
      disp_q      <= 16'h0000;
      disp_dp_q   <= 4'h0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fs_q        <= fs_d;
    end
  end

  assign an_n        = an_q;
  assign seg_n       = seg_q;
  assign dp_n        = dp_q;
  assign frame_start = fs_q;

endmodule
